// File: rtl/db9_splitter_scheduler_if.sv
// Signal bundle between the DB9 pins/control side and the splitter scheduler.
// The master side drives the raw pins and the mode select; the slave side
// (the scheduler) drives the splitter select and the committed joystick states.
interface db9_splitter_scheduler_if;
  logic       splitter_en;
  logic [5:0] db9_in;
  logic       sel_out;
  logic [5:0] joy1_out;
  logic [5:0] joy2_out;
  logic       joy1_valid;
  logic       joy2_valid;
  logic       glitch;

  modport master (
    output splitter_en, db9_in,
    input  sel_out, joy1_out, joy2_out, joy1_valid, joy2_valid, glitch
  );

  modport slave (
    input  splitter_en, db9_in,
    output sel_out, joy1_out, joy2_out, joy1_valid, joy2_valid, glitch
  );
endinterface

// File: rtl/db9_splitter_scheduler.sv
// Time-multiplexes one DB9 port between two joysticks through an external
// splitter. Each slot drives the select line, waits for the splitter to
// settle, takes two samples and commits the reading only if both agree.
// With the splitter disabled, the port is tracked directly as joystick 1.
module db9_splitter_scheduler #(
  parameter int SLOT_CYCLES   = 70000,
  parameter int SETTLE_CYCLES = 56
) (
  input logic                    clk,
  input logic                    rst_n,
  db9_splitter_scheduler_if.slave bus
);
  localparam int DATA_W = 6;
  localparam int CNT_W  = $clog2(SLOT_CYCLES);
  localparam logic [CNT_W-1:0]  SAMPLE_A_AT = CNT_W'(SETTLE_CYCLES);
  localparam logic [CNT_W-1:0]  SAMPLE_B_AT = CNT_W'(2 * SETTLE_CYCLES);
  localparam logic [CNT_W-1:0]  SLOT_LAST   = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [DATA_W-1:0] RELEASED    = '1;

  typedef enum logic [1:0] {
    DIRECT = 2'd0,
    SLOT1  = 2'd1,
    SLOT2  = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              slot_end;
  logic              in_slot;
  logic              keep_slot;
  logic              take_a;
  logic              take_b;

  logic [DATA_W-1:0] meta;
  logic [DATA_W-1:0] sync_in;
  logic [DATA_W-1:0] sample_a;
  logic [DATA_W-1:0] sample_b_p0;
  logic [DATA_W-1:0] sample_b_p1;
  logic              match_p1;
  logic              tgt_p0;
  logic              tgt_p1;
  logic              vld_p0;
  logic              vld_p1;

  // Slot sequencing: leave for DIRECT as soon as the splitter is disabled.
  always_comb begin
    state_nxt = state;
    slot_end  = (cnt == SLOT_LAST);
    case (state)
      DIRECT:  if (bus.splitter_en) state_nxt = SLOT1;
      SLOT1: begin
        if (!bus.splitter_en) state_nxt = DIRECT;
        else if (slot_end)    state_nxt = SLOT2;
      end
      SLOT2: begin
        if (!bus.splitter_en) state_nxt = DIRECT;
        else if (slot_end)    state_nxt = SLOT1;
      end
      default: state_nxt = SLOT1;
    endcase
  end

  assign in_slot   = (state != DIRECT);
  assign keep_slot = (state_nxt != DIRECT);
  assign take_a    = in_slot && (cnt == SAMPLE_A_AT);
  assign take_b    = in_slot && keep_slot && (cnt == SAMPLE_B_AT);

  // Two-flop synchronizer for the asynchronous pins; idle level is all released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta    <= RELEASED;
      sync_in <= RELEASED;
    end else begin
      meta    <= bus.db9_in;
      sync_in <= meta;
    end
  end

  // State, slot counter and registered select; select flips on the wrap edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SLOT1;
      cnt         <= '0;
      bus.sel_out <= 1'b1;
    end else begin
      state <= state_nxt;
      if (!in_slot || !keep_slot || slot_end) cnt <= '0;
      else                                    cnt <= cnt + CNT_W'(1);
      bus.sel_out <= (state_nxt != SLOT2);
    end
  end

  // Commit pipeline valids; cleared when leaving splitter mode so nothing stale commits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      // p0: second sample taken
      vld_p0 <= take_b;
      // p1: samples compared
      vld_p1 <= vld_p0 && keep_slot;
    end
  end

  // Sample capture and compare datapath (no reset needed, qualified by the valids).
  always_ff @(posedge clk) begin
    if (take_a) sample_a <= sync_in;
    if (take_b) begin
      sample_b_p0 <= sync_in;
      tgt_p0      <= (state == SLOT2);
    end
    sample_b_p1 <= sample_b_p0;
    match_p1    <= (sample_b_p0 == sample_a);
    tgt_p1      <= tgt_p0;
  end

  // Output registers: direct tracking, stable-sample commit, or glitch report.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.joy1_out   <= RELEASED;
      bus.joy2_out   <= RELEASED;
      bus.joy1_valid <= 1'b0;
      bus.joy2_valid <= 1'b0;
      bus.glitch     <= 1'b0;
    end else begin
      bus.joy1_valid <= 1'b0;
      bus.joy2_valid <= 1'b0;
      bus.glitch     <= 1'b0;
      if (!keep_slot) begin
        bus.joy2_out <= RELEASED;
        if (state == DIRECT) begin
          bus.joy1_out   <= sync_in;
          bus.joy1_valid <= (sync_in != bus.joy1_out);
        end
      end else if (vld_p1) begin
        // p2: committed to the selected joystick
        if (!match_p1) begin
          bus.glitch <= 1'b1;
        end else if (tgt_p1) begin
          bus.joy2_out   <= sample_b_p1;
          bus.joy2_valid <= 1'b1;
        end else begin
          bus.joy1_out   <= sample_b_p1;
          bus.joy1_valid <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_db9_splitter_scheduler.sv
// Bench for db9_splitter_scheduler: directed scenarios plus random pins and
// mode changes, scored against a history-based model of the slot schedule.
module tb_db9_splitter_scheduler;
  localparam int         SLOT   = 20;
  localparam int         SETTLE = 4;
  localparam int         MAXC   = 8192;
  localparam logic [5:0] IDLE   = 6'h3F;

  typedef struct {
    int         cyc;
    int         kind;   // 1 = joy1 commit, 2 = joy2 commit, 3 = glitch
    logic [5:0] val;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc;
  int   vectors = 0;
  int   miscompares = 0;

  ev_t        q[$];
  logic       en_h    [MAXC];
  logic [5:0] pin_h   [MAXC];
  logic       split_h [MAXC];
  logic       tgt_h   [MAXC];
  int         pos_h   [MAXC];
  logic       exp_sel [MAXC];
  logic       dir_h   [MAXC];

  db9_splitter_scheduler_if bus ();

  db9_splitter_scheduler #(
    .SLOT_CYCLES  (SLOT),
    .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // cycle index since the last reset release (cycle 0 is the slot start)
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic logic [5:0] sync_of(input int k);
    return (k >= 2) ? pin_h[k-2] : IDLE;
  endfunction

  task automatic push_ev(input int at, input int kind, input logic [5:0] val);
    ev_t e;
    e.cyc  = at;
    e.kind = kind;
    e.val  = val;
    q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, want);
    end
  endtask

  // Reference model: records pins/mode per cycle and schedules expected events.
  logic       m_split;
  int         m_start;
  logic [5:0] m_joy1;
  always @(negedge clk) begin
    int         c;
    int         b;
    int         o;
    logic [5:0] a;
    logic [5:0] v;
    if (!rst_n) begin
      m_split = 1'b1;
      m_start = 0;
      m_joy1  = IDLE;
    end else if (cyc < MAXC) begin
      c = cyc;
      en_h[c]  = bus.splitter_en;
      pin_h[c] = bus.db9_in;
      if (c == 0) begin
        m_split = 1'b1;
        m_start = 0;
      end else if (m_split && !en_h[c-1]) begin
        m_split = 1'b0;
      end else if (!m_split && en_h[c-1]) begin
        m_split = 1'b1;
        m_start = c;
      end
      o = (c - m_start) % (2 * SLOT);
      split_h[c] = m_split;
      dir_h[c]   = !m_split;
      pos_h[c]   = o % SLOT;
      tgt_h[c]   = (o >= SLOT);
      exp_sel[c] = !m_split || (o < SLOT);
      // direct mode: joystick 1 follows the pins three cycles late
      if (!m_split && !en_h[c]) begin
        v = sync_of(c);
        if (v != m_joy1) begin
          push_ev(c + 1, 1, v);
          m_joy1 = v;
        end
      end
      // splitter mode: second sample two cycles ago, commit visible next cycle
      b = c - 2;
      if (b >= 0 && split_h[b] && pos_h[b] == 2 * SETTLE && en_h[b] && en_h[b+1] && en_h[c]) begin
        a = sync_of(b - SETTLE);
        v = sync_of(b);
        if (a != v) begin
          push_ev(c + 1, 3, 6'h00);
        end else if (tgt_h[b]) begin
          push_ev(c + 1, 2, v);
        end else begin
          push_ev(c + 1, 1, v);
          m_joy1 = v;
        end
      end
    end
  end

  // Monitor: pops scheduled events and compares every observable output.
  logic [5:0] exp_j1 = IDLE;
  logic [5:0] exp_j2 = IDLE;
  always begin
    int       c;
    ev_t      e;
    logic [2:0] want;
    @(negedge clk or negedge rst_n);
    #1;
    if (!rst_n) begin
      q.delete();
      exp_j1 = IDLE;
      exp_j2 = IDLE;
      check("reset_state",
            32'({bus.sel_out, bus.joy1_out, bus.joy2_out, bus.joy1_valid, bus.joy2_valid, bus.glitch}),
            32'({1'b1, IDLE, IDLE, 3'b000}));
    end else if (cyc < MAXC) begin
      c    = cyc;
      want = 3'b000;
      while (q.size() > 0 && q[0].cyc < c) begin
        e = q.pop_front();
        vectors++;
        miscompares++;
        $display("FAIL stale_event cyc=%0d event_cyc=%0d kind=%0d", c, e.cyc, e.kind);
      end
      if (q.size() > 0 && q[0].cyc == c) begin
        e = q.pop_front();
        case (e.kind)
          1: begin want = 3'b100; exp_j1 = e.val; end
          2: begin want = 3'b010; exp_j2 = e.val; end
          default: want = 3'b001;
        endcase
      end
      if (dir_h[c]) exp_j2 = IDLE;
      check("pulses", 32'({bus.joy1_valid, bus.joy2_valid, bus.glitch}), 32'(want));
      check("joy1_out", 32'(bus.joy1_out), 32'(exp_j1));
      check("joy2_out", 32'(bus.joy2_out), 32'(exp_j2));
      check("sel_out", 32'(bus.sel_out), 32'(exp_sel[c]));
    end
  end

  task automatic do_reset(input logic en, input logic [5:0] pins);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    bus.splitter_en = en;
    bus.db9_in      = pins;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  task automatic step(input logic en, input logic [5:0] pins);
    @(posedge clk);
    #1;
    bus.splitter_en = en;
    bus.db9_in      = pins;
  endtask

  initial begin
    rst_n           = 1'b0;
    bus.splitter_en = 1'b1;
    bus.db9_in      = 6'h3E;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;

    // constant pins in splitter mode
    repeat (80) step(1'b1, 6'h3E);

    // splitter presents a different joystick on each select value
    repeat (12 * SLOT + SLOT) begin
      @(posedge clk);
      #1;
      bus.db9_in = bus.sel_out ? 6'h2F : 6'h1D;
    end

    // unstable first slot, then drop the splitter mid-SLOT2 at cnt 7
    do_reset(1'b1, IDLE);
    while (cyc < 27) begin
      @(posedge clk);
      #1;
      bus.splitter_en = (cyc != 27);
      bus.db9_in      = (cyc == 6) ? 6'h3B : IDLE;
    end
    repeat (10) step(1'b0, IDLE);
    repeat (10) step(1'b0, 6'h37);
    repeat (60) begin
      @(posedge clk);
      #1;
      if ($urandom_range(0, 5) == 0) bus.db9_in = 6'($urandom_range(0, 63));
    end

    // back to splitter mode with occasional pin changes
    repeat (100) begin
      @(posedge clk);
      #1;
      bus.splitter_en = 1'b1;
      if ($urandom_range(0, 14) == 0) bus.db9_in = 6'($urandom_range(0, 63));
    end

    // asynchronous reset between sample A and sample B of SLOT1
    do_reset(1'b1, 6'h15);
    while (cyc < 6) step(1'b1, 6'h15);
    do_reset(1'b1, 6'h2A);
    repeat (60) step(1'b1, 6'h2A);

    // reset released with the splitter disabled
    do_reset(1'b0, 6'h33);
    repeat (40) begin
      @(posedge clk);
      #1;
      if ($urandom_range(0, 7) == 0) bus.db9_in = 6'($urandom_range(0, 63));
    end

    // long random run: pin changes and rare mode changes
    do_reset(1'b1, IDLE);
    repeat (3000) begin
      @(posedge clk);
      #1;
      if ($urandom_range(0, 299) == 0) bus.splitter_en = ~bus.splitter_en;
      if ($urandom_range(0, 11) == 0)  bus.db9_in = 6'($urandom_range(0, 63));
    end
    repeat (30) step(bus.splitter_en, bus.db9_in);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
